// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction-fetch / load-store memory arbiter:
// default widths, the starvation limit, FSM state and transaction owner encodings.
package mem_arbiter_pkg;

  localparam int ARB_ADDR_W    = 64;
  localparam int ARB_DATA_W    = 64;
  localparam int ARB_STRB_W    = ARB_DATA_W / 8;
  localparam int ARB_LS_STREAK = 4;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch (IF) and load/store (LS).
// One transaction is outstanding at a time. LS normally has priority, but IF is
// forced through after LS_STREAK back-to-back LS grants while IF was waiting.
// The response is returned only to the requester that owns the transaction; an
// IF response can be discarded by a fetch redirect (if_flush).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = ARB_ADDR_W,
  parameter int DATA_W    = ARB_DATA_W,
  parameter int LS_STREAK = ARB_LS_STREAK
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_flush,
  output logic                if_resp_valid,
  output logic [DATA_W-1:0]   if_rdata,

  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic                ls_wen,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wmask,
  output logic                ls_resp_valid,
  output logic [DATA_W-1:0]   ls_rdata,

  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int STRB_W   = DATA_W / 8;
  localparam int STREAK_W = $clog2(LS_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(LS_STREAK);

  arb_state_e            state;
  arb_state_e            state_next;
  owner_e                owner;
  logic                  drop;
  logic [STREAK_W-1:0]   streak;
  logic                  if_wins;
  logic                  ls_wins;
  logic                  if_hs;
  logic                  ls_hs;

  assign if_hs = if_req_valid && if_req_ready;
  assign ls_hs = ls_req_valid && ls_req_ready;

  // Pick the winner: LS first, unless IF has been starved for LS_STREAK grants.
  always_comb begin
    if_wins = 1'b0;
    ls_wins = 1'b0;
    if (if_req_valid && (!ls_req_valid || streak == STREAK_MAX)) begin
      if_wins = 1'b1;
    end else if (ls_req_valid) begin
      ls_wins = 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state plus the combinational readys and the memory request strobe.
  always_comb begin
    state_next    = state;
    if_req_ready  = 1'b0;
    ls_req_ready  = 1'b0;
    mem_req_valid = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (!rst) begin
          if_req_ready = if_wins;
          ls_req_ready = ls_wins;
          if (if_wins || ls_wins) begin
            state_next = ARB_REQ;
          end
        end
      end
      ARB_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          state_next = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (mem_resp_valid) begin
          state_next = ARB_IDLE;
        end
      end
      default: begin
        state_next = ARB_IDLE;
      end
    endcase
  end

  // Latch the winning request so the memory port sees stable fields until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner     <= OWN_IF;
      mem_addr  <= '0;
      mem_wen   <= 1'b0;
      mem_wdata <= '0;
      mem_wmask <= '0;
    end else if (if_hs) begin
      owner     <= OWN_IF;
      mem_addr  <= if_addr;
      mem_wen   <= 1'b0;
      mem_wdata <= '0;
      mem_wmask <= '0;
    end else if (ls_hs) begin
      owner     <= OWN_LS;
      mem_addr  <= ls_addr;
      mem_wen   <= ls_wen;
      mem_wdata <= ls_wdata;
      mem_wmask <= ls_wmask[STRB_W-1:0];
    end
  end

  // Count consecutive LS grants that made a waiting IF lose arbitration.
  always_ff @(posedge clk) begin
    if (rst) begin
      streak <= '0;
    end else if (if_hs) begin
      streak <= '0;
    end else if (ls_hs) begin
      if (!if_req_valid) begin
        streak <= '0;
      end else if (streak != STREAK_MAX) begin
        streak <= streak + STREAK_W'(1);
      end
    end
  end

  // Remember a fetch redirect that hit an in-flight IF transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop <= 1'b0;
    end else if (state == ARB_IDLE || (state == ARB_WAIT && mem_resp_valid)) begin
      drop <= 1'b0;
    end else if (owner == OWN_IF && if_flush) begin
      drop <= 1'b1;
    end
  end

  // Route the memory response to its owner as a one-cycle registered pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_resp_valid <= 1'b0;
      if_rdata      <= '0;
      ls_resp_valid <= 1'b0;
      ls_rdata      <= '0;
    end else begin
      if_resp_valid <= 1'b0;
      if_rdata      <= '0;
      ls_resp_valid <= 1'b0;
      ls_rdata      <= '0;
      if (state == ARB_WAIT && mem_resp_valid) begin
        if (owner == OWN_LS) begin
          ls_resp_valid <= 1'b1;
          ls_rdata      <= mem_wen ? '0 : mem_rdata;
        end else if (!drop && !if_flush) begin
          if_resp_valid <= 1'b1;
          if_rdata      <= mem_rdata;
        end
      end
    end
  end

endmodule
